// File: rtl/button_click_classifier.sv
// Classifies a debounced button level into single click, double click and long press events.
// One shared counter measures both press duration and release gap; all outputs are registered.
module button_click_classifier #(
    parameter int LONG_PRESS_CLK_CNT       = 16777216,
    parameter int DOUBLE_CLICK_GAP_CLK_CNT = 8388608
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_debounced,
    output logic click_pulse,
    output logic double_click_pulse,
    output logic long_press_pulse,
    output logic long_held
);

    localparam int MAX_CNT = (LONG_PRESS_CLK_CNT > DOUBLE_CLICK_GAP_CLK_CNT) ?
                             LONG_PRESS_CLK_CNT : DOUBLE_CLICK_GAP_CLK_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    // Terminal values are one below the sample counts: the sample that matches
    // the terminal value is itself the N-th sample of the run.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CLK_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_CLICK_GAP_CLK_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] S_IDLE           = 3'd0;
    localparam logic [2:0] S_PRESSED        = 3'd1;
    localparam logic [2:0] S_WAIT_GAP       = 3'd2;
    localparam logic [2:0] S_SECOND_PRESSED = 3'd3;
    localparam logic [2:0] S_LONG_HELD      = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_click;
    logic             r_double;
    logic             r_long;
    logic             r_held;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_click;
    logic             w_double;
    logic             w_long;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_click     = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (btn_debounced) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (!btn_debounced) begin
                    w_state_nxt = S_WAIT_GAP;
                    w_cnt_nxt   = CNT_ONE;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nxt = S_LONG_HELD;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_WAIT_GAP: begin
                if (btn_debounced) begin
                    w_state_nxt = S_SECOND_PRESSED;
                    w_cnt_nxt   = CNT_ONE;
                end else if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_click     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_SECOND_PRESSED: begin
                // A second press that turns long swallows the pending first click.
                if (!btn_debounced) begin
                    w_state_nxt = S_IDLE;
                    w_double    = 1'b1;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nxt = S_LONG_HELD;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_LONG_HELD: begin
                if (!btn_debounced) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_click  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_click  <= w_click;
            r_double <= w_double;
            r_long   <= w_long;
            r_held   <= (w_state_nxt == S_LONG_HELD);
        end
    end

    assign click_pulse        = r_click;
    assign double_click_pulse = r_double;
    assign long_press_pulse   = r_long;
    assign long_held          = r_held;

endmodule

// File: tb/tb_button_click_classifier.sv
// Directed bench for button_click_classifier with short thresholds (long = 8, gap = 5).
// Each step applies one button sample and checks all four outputs right after that edge.
module tb_button_click_classifier;

    logic clk;
    logic reset_n;
    logic btn_debounced;
    logic click_pulse;
    logic double_click_pulse;
    logic long_press_pulse;
    logic long_held;

    int checks   = 0;
    int failures = 0;

    button_click_classifier #(
        .LONG_PRESS_CLK_CNT      (8),
        .DOUBLE_CLICK_GAP_CLK_CNT(5)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .btn_debounced     (btn_debounced),
        .click_pulse       (click_pulse),
        .double_click_pulse(double_click_pulse),
        .long_press_pulse  (long_press_pulse),
        .long_held         (long_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ec, input logic ed,
                           input logic el, input logic eh);
        chk({tag, "/click"},  click_pulse,        ec);
        chk({tag, "/double"}, double_click_pulse, ed);
        chk({tag, "/long"},   long_press_pulse,   el);
        chk({tag, "/held"},   long_held,          eh);
    endtask

    // One button sample: drive, let the rising edge take it, check the registered outputs.
    task automatic step(input logic b, input logic ec, input logic ed,
                        input logic el, input logic eh, input string tag);
        btn_debounced = b;
        @(posedge clk);
        #1;
        chk_all(tag, ec, ed, el, eh);
    endtask

    task automatic run(input logic b, input int n, input logic eh, input string tag);
        for (int i = 0; i < n; i++) begin
            step(b, 1'b0, 1'b0, 1'b0, eh, tag);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        btn_debounced = 1'b0;
        #2;
        chk_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_all("reset_release", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single click: 3 high, click one cycle after the 5th low sample.
        run(1'b1, 3, 1'b0, "single_hi");
        run(1'b0, 4, 1'b0, "single_lo");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "single_click");
        run(1'b0, 3, 1'b0, "single_after");

        // Double click: second press starts on the 5th low sample.
        run(1'b1, 3, 1'b0, "dbl_hi1");
        run(1'b0, 4, 1'b0, "dbl_lo");
        run(1'b1, 3, 1'b0, "dbl_hi2");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "dbl_pulse");
        run(1'b0, 6, 1'b0, "dbl_after");

        // 7 high samples is still a short press.
        run(1'b1, 7, 1'b0, "short7_hi");
        run(1'b0, 4, 1'b0, "short7_lo");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "short7_click");
        run(1'b0, 2, 1'b0, "short7_after");

        // 20 high samples: long after the 8th, held through the 20th.
        run(1'b1, 7, 1'b0, "long20_pre");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "long20_pulse");
        run(1'b1, 12, 1'b1, "long20_held");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "long20_release");
        run(1'b0, 6, 1'b0, "long20_after");

        // Gap boundary: 5 lows complete the click, next press is a fresh sequence.
        run(1'b1, 3, 1'b0, "gap_hi1");
        run(1'b0, 4, 1'b0, "gap_lo1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap_click1");
        run(1'b1, 3, 1'b0, "gap_hi2");
        run(1'b0, 4, 1'b0, "gap_lo2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap_click2");
        run(1'b0, 2, 1'b0, "gap_after");

        // Reset mid-press with the button still high; count restarts at reset release.
        run(1'b1, 6, 1'b0, "rst_press_hi");
        reset_n = 1'b0;
        #1;
        chk_all("rst_press_async", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_press_during", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        run(1'b1, 7, 1'b0, "rst_press_re");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "rst_press_long");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_press_release");
        run(1'b0, 6, 1'b0, "rst_press_after");

        // Asynchronous reset clears long_held between clock edges.
        run(1'b1, 7, 1'b0, "rst_held_pre");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "rst_held_long");
        run(1'b1, 2, 1'b1, "rst_held_hold");
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("rst_held_async", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_debounced = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run(1'b0, 6, 1'b0, "rst_held_after");

        // Double then long: second press turns long, pending click discarded.
        run(1'b1, 3, 1'b0, "dl_hi1");
        run(1'b0, 2, 1'b0, "dl_lo");
        run(1'b1, 7, 1'b0, "dl_hi2");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "dl_long");
        run(1'b1, 2, 1'b1, "dl_held");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "dl_release");
        run(1'b0, 6, 1'b0, "dl_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_click_classifier.md
BUTTON_CLICK_CLASSIFIER -- requirements
Module: button_click_classifier

Interface
REQ-001 SHALL have parameter LONG_PRESS_CLK_CNT, default 16777216: consecutive high samples that classify a press as long; legal range >= 2.
REQ-002 SHALL have parameter DOUBLE_CLICK_GAP_CLK_CNT, default 8388608: maximum consecutive low samples between two presses of a double click; legal range >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_debounced  input  1  debounced, clk-synchronous button level from the upstream debouncer; 1 = pressed.
REQ-006 SHALL have port click_pulse  output  1  one-cycle pulse marking a completed single click.
REQ-007 SHALL have port double_click_pulse  output  1  one-cycle pulse marking a completed double click.
REQ-008 SHALL have port long_press_pulse  output  1  one-cycle pulse marking that a press reached long duration.
REQ-009 SHALL have port long_held  output  1  level; high while a long press is still held.

Function
REQ-010 SHALL implement an FSM with states IDLE, PRESSED, WAIT_GAP, SECOND_PRESSED, LONG_HELD, plus one shared counter cnt of width $clog2(max(LONG_PRESS_CLK_CNT, DOUBLE_CLICK_GAP_CLK_CNT)+1).
REQ-011 All outputs SHALL be registered; every pulse is high for exactly one cycle, in the cycle after the triggering sample.
REQ-012 IDLE: btn=1 -> PRESSED, cnt<=1; btn=0 -> stay.
REQ-013 PRESSED: btn=0 -> WAIT_GAP, cnt<=1; btn=1 and cnt==LONG_PRESS_CLK_CNT-1 -> LONG_HELD, long_press_pulse<=1; otherwise cnt<=cnt+1.
REQ-014 WAIT_GAP: btn=1 -> SECOND_PRESSED, cnt<=1; btn=0 and cnt==DOUBLE_CLICK_GAP_CLK_CNT-1 -> IDLE, click_pulse<=1; otherwise cnt<=cnt+1.
REQ-015 SECOND_PRESSED: btn=0 -> IDLE, double_click_pulse<=1; btn=1 and cnt==LONG_PRESS_CLK_CNT-1 -> LONG_HELD, long_press_pulse<=1, pending first click discarded; otherwise cnt<=cnt+1.
REQ-016 LONG_HELD: long_held=1; btn=0 -> IDLE with no click pulse; btn=1 -> stay, cnt held.
REQ-017 Result: long_press_pulse rises after the LONG_PRESS_CLK_CNT-th consecutive high sample; a press of LONG_PRESS_CLK_CNT-1 samples is a short press.
REQ-018 Result: click_pulse rises after the DOUBLE_CLICK_GAP_CLK_CNT-th consecutive low sample following a short press; a second press starting on any earlier low-count sample forms a double click.
REQ-019 At most one of click_pulse, double_click_pulse, long_press_pulse SHALL be high in any cycle.
REQ-020 cnt SHALL never exceed its terminal value; no wrap-around in any state.
REQ-021 long_held SHALL be registered, rising in the same cycle as long_press_pulse and falling the cycle after the first low sample in LONG_HELD.

Reset
REQ-022 reset_n=0 SHALL immediately force state IDLE, cnt 0, and all four outputs 0, regardless of clk.
REQ-023 Reset mid-operation SHALL abandon any pending click/double/long classification without emitting a pulse.
REQ-024 After reset_n deasserts, a btn_debounced already high SHALL be treated as a new press starting at the first sampled edge.

Verification (LONG_PRESS_CLK_CNT=8, DOUBLE_CLICK_GAP_CLK_CNT=5)
REQ-025 Single click: btn high 3 cycles then low -> click_pulse one cycle after 5th low sample; no other pulse.
REQ-026 Double click: high 3, low 4, high 3, low -> double_click_pulse one cycle after first low sample of second release; click_pulse never asserts.
REQ-027 Long boundary: high 7 then low -> eventual click_pulse, no long; high 20 -> long_press_pulse after 8th high sample, long_held high through sample 20, falls after release, no click.
REQ-028 Gap boundary: high 3, low 5, high 3 -> click_pulse after 5th low sample, second press starts a new sequence (second click_pulse after its gap).
REQ-029 Reset mid-press: high 6, reset_n low 2 cycles with btn still high -> outputs 0 asynchronously; after release of reset_n, long_press_pulse after 8th high sample counted from reset release.
REQ-030 Double-then-long: high 3, low 2, high 10 -> long_press_pulse after 8th sample of second press, no click or double pulse.
